// File: rtl/fifo_read_ctrl.sv
// Read-side consumer for the asynchronous FIFO: pops words, absorbs the read latency and re-issues them on a valid/ready stream.
// Optional read-transfer counter (rd_count / rd_count_clr) is built when FIFO_RD_STATS_EN is defined.
module fifo_read_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1
`ifdef FIFO_RD_STATS_EN
   ,
   parameter int CNT_WIDTH  = 16
`endif
) (
   input  logic                  read_clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  r_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  r_en,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy
`ifdef FIFO_RD_STATS_EN
   ,
   input  logic                  rd_count_clr,
   output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

   localparam int BUF_DEPTH = RD_LATENCY + 1;
   localparam int PTR_W     = (BUF_DEPTH > 2) ? 2 : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
   localparam logic [2:0]       DEPTH_L  = 3'(BUF_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [1:0]            r_occ;
   logic [1:0]            r_infl;
   logic [RD_LATENCY-1:0] r_dly;
   logic                  r_m_valid;
   logic [1:0]            w_occ_nxt;
   logic [1:0]            w_infl_nxt;
   logic [2:0]            w_level;
   logic                  w_pop;
   logic                  w_land;
   logic                  w_room;
   logic                  w_drained;

   function automatic logic [PTR_W-1:0] ptr_adv(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
   endfunction

   assign w_pop     = r_m_valid & m_ready;
   assign w_land    = r_dly[RD_LATENCY-1];
   // Level the buffer would hold if every outstanding read landed after this cycle's pop.
   assign w_level   = {1'b0, r_occ} + {1'b0, r_infl} - {2'b00, w_pop};
   assign w_room    = (w_level < DEPTH_L);
   assign w_occ_nxt = r_occ + {1'b0, w_land} - {1'b0, w_pop};
   assign w_infl_nxt = r_infl + {1'b0, r_en} - {1'b0, w_land};
   // Independent of r_en so the drain decision does not loop through the pop request.
   assign w_drained = (w_occ_nxt == 2'd0) && ((r_infl - {1'b0, w_land}) == 2'd0);

   assign m_valid = r_m_valid;
   assign m_data  = r_buf[r_rd_ptr];
   assign busy    = (r_state != IDLE);

   // Next-state and pop-request decode.
   always_comb begin
      w_state_nxt = r_state;
      r_en        = 1'b0;
      case (r_state)
         IDLE: begin
            if (enable) w_state_nxt = RUN;
            else        w_state_nxt = IDLE;
         end
         RUN: begin
            r_en = enable & ~r_empty & w_room;
            if (!enable) w_state_nxt = ((r_occ | r_infl) != 2'd0) ? DRAIN : IDLE;
            else         w_state_nxt = RUN;
         end
         DRAIN: begin
            if (enable)         w_state_nxt = RUN;
            else if (w_drained) w_state_nxt = IDLE;
            else                w_state_nxt = DRAIN;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge read_clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Read-latency delay line, output buffer, pointers and occupancy.
   always_ff @(posedge read_clk or posedge reset) begin
      if (reset) begin
         r_dly     <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_occ     <= 2'd0;
         r_infl    <= 2'd0;
         r_m_valid <= 1'b0;
         for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
      end else begin
         r_dly[0] <= r_en;
         for (int i = 1; i < RD_LATENCY; i++) r_dly[i] <= r_dly[i-1];
         if (w_land) begin
            r_buf[r_wr_ptr] <= fifo_data;
            r_wr_ptr        <= ptr_adv(r_wr_ptr);
         end
         if (w_pop) r_rd_ptr <= ptr_adv(r_rd_ptr);
         r_occ     <= w_occ_nxt;
         r_infl    <= w_infl_nxt;
         r_m_valid <= (w_occ_nxt != 2'd0);
      end
   end

`ifdef FIFO_RD_STATS_EN
   // Saturating count of downstream transfers; clear wins over increment.
   always_ff @(posedge read_clk or posedge reset) begin
      if (reset)                          rd_count <= '0;
      else if (rd_count_clr)              rd_count <= '0;
      else if (w_pop && (rd_count != '1)) rd_count <= rd_count + CNT_WIDTH'(1);
   end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed self-checking bench for fifo_read_ctrl (RD_LATENCY = 1) driven by a behavioural FIFO model.
module tb_fifo_read_ctrl;

   logic       read_clk = 1'b0;
   logic       reset    = 1'b1;
   logic       enable   = 1'b0;
   logic       m_ready  = 1'b0;
   logic       r_empty;
   logic [7:0] fifo_data;
   logic       r_en;
   logic [7:0] m_data;
   logic       m_valid;
   logic       busy;
`ifdef FIFO_RD_STATS_EN
   logic        rd_count_clr = 1'b0;
   logic [15:0] rd_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] fmem [256];
   int wr_cnt = 0;
   int rd_cnt = 0;

   int         cyc = 0;
   int         en_q[$];
   logic [7:0] got_q[$];
   int         got_cyc[$];

   fifo_read_ctrl #(.DATA_WIDTH(8), .RD_LATENCY(1)) dut (
      .read_clk  (read_clk),
      .reset     (reset),
      .enable    (enable),
      .r_empty   (r_empty),
      .fifo_data (fifo_data),
      .r_en      (r_en),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .busy      (busy)
`ifdef FIFO_RD_STATS_EN
      ,
      .rd_count_clr (rd_count_clr),
      .rd_count     (rd_count)
`endif
   );

   always #5 read_clk = ~read_clk;

   // FIFO model with one cycle read latency; shares the reset, which empties it.
   assign r_empty = (wr_cnt == rd_cnt);
   always @(posedge read_clk or posedge reset) begin
      if (reset) begin
         rd_cnt    <= wr_cnt;
         fifo_data <= 8'h00;
      end else if (r_en) begin
         fifo_data <= fmem[rd_cnt[7:0]];
         rd_cnt    <= rd_cnt + 1;
      end
   end

   // Per-cycle log of pops and downstream transfers, sampled mid-cycle.
   always @(negedge read_clk) begin
      cyc = cyc + 1;
      if (r_en === 1'b1) en_q.push_back(cyc);
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
         got_q.push_back(m_data);
         got_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge read_clk);
      #1;
   endtask

   task automatic at_mid();
      @(negedge read_clk);
      #1;
   endtask

   task automatic load(input int n, input logic [7:0] first);
      for (int i = 0; i < n; i++) begin
         fmem[wr_cnt[7:0]] = first + 8'(i);
         wr_cnt = wr_cnt + 1;
      end
   endtask

   function automatic logic [31:0] got_at(input int idx);
      return (idx < got_q.size()) ? {24'h0, got_q[idx]} : 32'hDEAD;
   endfunction

   task automatic check_words(input string tag, input int base, input int n, input logic [7:0] first);
      for (int i = 0; i < n; i++) check(tag, got_at(base + i), {24'h0, first + 8'(i)});
   endtask

   int  eb, gb, fall_cyc;
   bit  found;

   initial begin
      // Reset state
      @(posedge read_clk);
      #1;
      check("rst_r_en", r_en, 32'h0);
      check("rst_m_valid", m_valid, 32'h0);
      check("rst_m_data", m_data, 32'h0);
      check("rst_busy", busy, 32'h0);
      #5;
      reset  = 1'b0;
      enable = 1'b1;

      // Empty FIFO: no pops, busy from the cycle after enable
      #1;
      check("empty_busy_pre", busy, 32'h0);
      repeat (5) at_mid();
      check("empty_busy", busy, 32'h1);
      check("empty_r_en_cnt", 32'(en_q.size()), 32'h0);
      check("empty_m_valid", m_valid, 32'h0);
      tick();
      enable = 1'b0;
      repeat (3) tick();

      // Streaming 0x01..0x0A with m_ready high
      eb = en_q.size();
      gb = got_q.size();
      load(10, 8'h01);
      m_ready = 1'b1;
      enable  = 1'b1;
      repeat (20) tick();
      check("stream_r_en_cnt", 32'(en_q.size() - eb), 32'd10);
      check("stream_xfer_cnt", 32'(got_q.size() - gb), 32'd10);
      if (got_q.size() - gb == 10 && en_q.size() - eb == 10) begin
         check("stream_latency", 32'(got_cyc[gb] - en_q[eb]), 32'd2);
         check("stream_span", 32'(got_cyc[gb+9] - got_cyc[gb]), 32'd9);
      end else begin
         check("stream_log_complete", 32'h0, 32'h1);
      end
      check_words("stream_word", gb, 10, 8'h01);
      enable = 1'b0;
      repeat (3) tick();
      check("stream_idle", busy, 32'h0);

      // Backpressure: two pops fill the buffer, head held
      eb = en_q.size();
      gb = got_q.size();
      m_ready = 1'b0;
      load(5, 8'h01);
      enable = 1'b1;
      repeat (8) tick();
      at_mid();
      check("bp_r_en_cnt", 32'(en_q.size() - eb), 32'd2);
      check("bp_m_valid", m_valid, 32'h1);
      check("bp_m_data", m_data, 32'h01);
      check("bp_r_en_now", r_en, 32'h0);
      tick();
      m_ready = 1'b1;
      repeat (10) tick();
      check("bp_xfer_cnt", 32'(got_q.size() - gb), 32'd5);
      check_words("bp_word", gb, 5, 8'h01);
      if (got_q.size() - gb == 5) check("bp_no_gap", 32'(got_cyc[gb+4] - got_cyc[gb]), 32'd4);
      else                        check("bp_log_complete", 32'h0, 32'h1);
      check("bp_r_en_total", 32'(en_q.size() - eb), 32'd5);
      enable = 1'b0;
      repeat (3) tick();

      // Enable drop after the third pop
      eb = en_q.size();
      gb = got_q.size();
      load(6, 8'h11);
      enable = 1'b1;
      found  = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         at_mid();
         if (en_q.size() - eb == 3) found = 1'b1;
      end
      check("drop_third_pop_seen", 32'(found), 32'h1);
      @(posedge read_clk);
      #1;
      enable = 1'b0;
      at_mid();
      check("drop_r_en_after", r_en, 32'h0);
      found    = 1'b0;
      fall_cyc = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         at_mid();
         if (busy === 1'b0) begin
            found    = 1'b1;
            fall_cyc = cyc;
         end
      end
      check("drop_idle_reached", 32'(found), 32'h1);
      check("drop_xfer_cnt", 32'(got_q.size() - gb), 32'd3);
      check_words("drop_word", gb, 3, 8'h11);
      if (got_q.size() - gb == 3) check("drop_busy_fall", 32'(fall_cyc), 32'(got_cyc[gb+2] + 1));
      else                        check("drop_log_complete", 32'h0, 32'h1);
      check("drop_r_en_total", 32'(en_q.size() - eb), 32'd3);

      // Asynchronous reset with words buffered and in flight
      m_ready = 1'b0;
      load(4, 8'h31);
      enable = 1'b1;
      found  = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         at_mid();
         if (m_valid === 1'b1) found = 1'b1;
      end
      check("rst2_fill_seen", 32'(found), 32'h1);
      reset  = 1'b1;
      enable = 1'b0;
      #1;
      check("rst2_m_valid", m_valid, 32'h0);
      check("rst2_r_en", r_en, 32'h0);
      check("rst2_busy", busy, 32'h0);
      check("rst2_m_data", m_data, 32'h0);
      tick();
      reset = 1'b0;
      eb = en_q.size();
      gb = got_q.size();
      load(3, 8'h51);
      m_ready = 1'b1;
      enable  = 1'b1;
      repeat (10) tick();
      check("rst2_xfer_cnt", 32'(got_q.size() - gb), 32'd3);
      check_words("rst2_word", gb, 3, 8'h51);
      check("rst2_r_en_cnt", 32'(en_q.size() - eb), 32'd3);

`ifdef FIFO_RD_STATS_EN
      // Transfer counter: clear coincides with the eighth transfer
      rd_count_clr = 1'b1;
      tick();
      rd_count_clr = 1'b0;
      check("stats_cleared", rd_count, 32'h0);
      gb = got_q.size();
      load(8, 8'h61);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         at_mid();
         if (got_q.size() - gb == 7) found = 1'b1;
      end
      check("stats_seven_seen", 32'(found), 32'h1);
      @(posedge read_clk);
      #1;
      rd_count_clr = 1'b1;
      check("stats_count7", rd_count, 32'd7);
      check("stats_8th_valid", m_valid, 32'h1);
      tick();
      rd_count_clr = 1'b0;
      check("stats_count0", rd_count, 32'h0);
`endif

      enable = 1'b0;
      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
